// File: rtl/alu_pkg.sv
// alu_pkg: FuncCode, TSC opcode/func constants and shared types for the ALU issue path.
package alu_pkg;

    // ALU FuncCode values as understood by the combinational ALU
    localparam logic [3:0] FC_ADD  = 4'h0;
    localparam logic [3:0] FC_SUB  = 4'h1;
    localparam logic [3:0] FC_ID   = 4'h2;
    localparam logic [3:0] FC_NOT  = 4'h3;
    localparam logic [3:0] FC_AND  = 4'h4;
    localparam logic [3:0] FC_OR   = 4'h5;
    localparam logic [3:0] FC_NAND = 4'h6;
    localparam logic [3:0] FC_NOR  = 4'h7;
    localparam logic [3:0] FC_XOR  = 4'h8;
    localparam logic [3:0] FC_XNOR = 4'h9;
    localparam logic [3:0] FC_LLS  = 4'hA;
    localparam logic [3:0] FC_LRS  = 4'hB;
    localparam logic [3:0] FC_ALS  = 4'hC;
    localparam logic [3:0] FC_ARS  = 4'hD;
    localparam logic [3:0] FC_TCP  = 4'hE;
    localparam logic [3:0] FC_ZERO = 4'hF;

    // TSC primary opcodes
    localparam logic [3:0] OP_RTYPE = 4'hF;
    localparam logic [3:0] OP_ADI   = 4'h4;
    localparam logic [3:0] OP_ORI   = 4'h5;
    localparam logic [3:0] OP_LHI   = 4'h6;

    // TSC R-type function field values
    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_AND = 6'd2;
    localparam logic [5:0] FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_TCP = 6'd5;
    localparam logic [5:0] FN_SHL = 6'd6;
    localparam logic [5:0] FN_SHR = 6'd7;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    // How operand B is formed: from the register file or from the 8-bit immediate
    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_SEXT,
        IMM_ZEXT,
        IMM_HIGH
    } imm_mode_t;

    // Everything the sequencer needs to know about one instruction
    typedef struct packed {
        logic [3:0] funcCode;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] dest;
        imm_mode_t  immMode;
        logic       aFromB;
        logic       ovfEn;
        logic       illegal;
    } decode_t;

    // Translate a legal R-type func field into the ALU FuncCode
    function automatic logic [3:0] rFuncToCode(input logic [5:0] func);
        logic [3:0] code;
        case (func)
            FN_ADD:  code = FC_ADD;
            FN_SUB:  code = FC_SUB;
            FN_AND:  code = FC_AND;
            FN_ORR:  code = FC_OR;
            FN_NOT:  code = FC_NOT;
            FN_TCP:  code = FC_TCP;
            FN_SHL:  code = FC_LLS;
            FN_SHR:  code = FC_ARS;
            default: code = FC_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational TSC instruction decoder feeding the ALU sequencer.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [15:0] i_instr,
    output decode_t     o_dec
);

    logic [3:0] w_op;
    logic [5:0] w_func;

    assign w_op   = i_instr[15:12];
    assign w_func = i_instr[5:0];

    // Map opcode/func onto FuncCode, operand routing, destination and legality
    always_comb begin
        o_dec.funcCode = FC_ZERO;
        o_dec.rs       = i_instr[11:10];
        o_dec.rt       = i_instr[9:8];
        o_dec.dest     = i_instr[9:8];
        o_dec.immMode  = IMM_NONE;
        o_dec.aFromB   = 1'b0;
        o_dec.ovfEn    = 1'b0;
        o_dec.illegal  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_dec.dest = i_instr[7:6];
                if (w_func > FN_SHR) begin
                    o_dec.illegal = 1'b1;
                end else begin
                    o_dec.funcCode = rFuncToCode(w_func);
                    o_dec.ovfEn    = (w_func == FN_ADD) || (w_func == FN_SUB);
                end
            end
            OP_ADI: begin
                o_dec.funcCode = FC_ADD;
                o_dec.immMode  = IMM_SEXT;
                o_dec.ovfEn    = 1'b1;
            end
            OP_ORI: begin
                o_dec.funcCode = FC_OR;
                o_dec.immMode  = IMM_ZEXT;
            end
            OP_LHI: begin
                o_dec.funcCode = FC_ID;
                o_dec.immMode  = IMM_HIGH;
                o_dec.aFromB   = 1'b1;
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts TSC instructions, drives the external ALU for one cycle,
// and writes the captured result into a small register file.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [3:0]            alu_FuncCode,
    input  logic [DATA_WIDTH-1:0] alu_C,
    input  logic                  alu_Overflow,
    output logic                  done,
    output logic [1:0]            done_rd,
    output logic [DATA_WIDTH-1:0] done_value,
    output logic                  ovf_sticky,
    output logic                  illegal,
    input  logic [1:0]            dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_aluA;
    logic [DATA_WIDTH-1:0] r_aluB;
    logic [3:0]            r_funcCode;
    logic [1:0]            r_dest;
    logic                  r_ovfEn;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_done;
    logic [1:0]            r_doneRd;
    logic                  r_ovfSticky;

    decode_t               w_dec;
    logic [7:0]            w_imm;
    logic [DATA_WIDTH-1:0] w_opA;
    logic [DATA_WIDTH-1:0] w_opB;
    logic                  w_ready;
    logic                  w_accept;

    alu_op_decode u_decode (
        .i_instr (instr),
        .o_dec   (w_dec)
    );

    assign w_imm    = instr[7:0];
    assign w_ready  = (r_state == IDLE);
    assign w_accept = w_ready && instr_valid && !w_dec.illegal;

    // Build the operands for the offered instruction from the register file or immediate
    always_comb begin
        w_opB = r_regs[w_dec.rt];
        case (w_dec.immMode)
            IMM_SEXT: w_opB = {{(DATA_WIDTH-8){w_imm[7]}}, w_imm};
            IMM_ZEXT: w_opB = {{(DATA_WIDTH-8){1'b0}}, w_imm};
            IMM_HIGH: w_opB = {w_imm, {(DATA_WIDTH-8){1'b0}}};
            default:  w_opB = r_regs[w_dec.rt];
        endcase
        w_opA = w_dec.aFromB ? w_opB : r_regs[w_dec.rs];
    end

    // Sequencer FSM: latch operands on accept, sample the ALU in EXEC, write back in WB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_funcCode  <= FC_ZERO;
            r_dest      <= '0;
            r_ovfEn     <= 1'b0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_doneRd    <= '0;
            r_ovfSticky <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aluA     <= w_opA;
                        r_aluB     <= w_opB;
                        r_funcCode <= w_dec.funcCode;
                        r_dest     <= w_dec.dest;
                        r_ovfEn    <= w_dec.ovfEn;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= alu_C;
                    if (r_ovfEn && alu_Overflow) begin
                        r_ovfSticky <= 1'b1;
                    end
                    r_done   <= 1'b1;
                    r_doneRd <= r_dest;
                    r_state  <= WB;
                end
                WB: begin
                    r_regs[r_dest] <= r_result;
                    r_funcCode     <= FC_ZERO;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready  = w_ready;
    assign illegal      = w_ready && instr_valid && w_dec.illegal;
    assign alu_A        = r_aluA;
    assign alu_B        = r_aluB;
    assign alu_FuncCode = r_funcCode;
    assign done         = r_done;
    assign done_rd      = r_doneRd;
    assign done_value   = r_result;
    assign ovf_sticky   = r_ovfSticky;
    assign dbg_rdata    = r_regs[dbg_raddr];

endmodule
